// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a small word FIFO, Tick-paced bit timing,
// 5..MAX_BITS data bits, 1/2 stop bits; parity framing only when UART_TX_PARITY_EN is defined.
module uart_tx_param #(
  parameter int unsigned MAX_BITS   = 9,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        Tick,
  input  logic                        TxValid,
  input  logic [MAX_BITS-1:0]         TxData,
  output logic                        TxReady,
  input  logic [3:0]                  NBits,
  input  logic                        StopBits,
  input  logic [1:0]                  ParityMode,
  output logic                        Tx,
  output logic                        TxBusy,
  output logic                        TxDone,
  output logic [$clog2(FIFO_DEPTH):0] FifoCount
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [MAX_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic                push, pop;

  state_e              state_q;
  logic [MAX_BITS-1:0] shift_q;
  logic [3:0]          nbits_q, bit_cnt_q;
  logic                stop2_q, stop_cnt_q;
  logic                par_en_q, par_bit_q;
  logic [TW-1:0]       tick_cnt_q;
  logic                tx_q, busy_q, done_q;
  logic                bit_end;

  logic [MAX_BITS-1:0] head_d;
  logic [3:0]          frame_nbits_d;
  logic                frame_par_en_d, frame_par_bit_d;

  function automatic logic [3:0] clamp_nbits(input logic [3:0] n);
    if (n < 4'd5) return 4'd5;
    if (n > 4'(MAX_BITS)) return 4'(MAX_BITS);
    return n;
  endfunction

  assign TxReady   = (count_q != CW'(FIFO_DEPTH));
  assign push      = TxValid & TxReady;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign FifoCount = count_q;
  assign Tx        = tx_q;
  assign TxBusy    = busy_q;
  assign TxDone    = done_q;

  assign head_d        = mem_q[rd_ptr_q];
  assign frame_nbits_d = clamp_nbits(NBits);
  assign bit_end       = Tick && (tick_cnt_q == TW'(OVERSAMPLE - 1));

`ifdef UART_TX_PARITY_EN
  function automatic logic data_parity(input logic [MAX_BITS-1:0] d, input logic [3:0] n);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < MAX_BITS; i++) begin
      if (i < 32'(n)) p = p ^ d[i];
    end
    return p;
  endfunction

  assign frame_par_en_d  = (ParityMode == 2'b01) || (ParityMode == 2'b10);
  assign frame_par_bit_d = data_parity(head_d, frame_nbits_d) ^ ParityMode[1];
`else
  logic unused_parity;
  assign unused_parity   = ^ParityMode;
  assign frame_par_en_d  = 1'b0;
  assign frame_par_bit_d = 1'b0;
`endif

  // Storage carries no reset; validity is tracked solely by count/pointers.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= TxData;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      nbits_q    <= 4'd5;
      bit_cnt_q  <= '0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tick_cnt_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Every state change happens on bit_end, so wrapping here also clears on entry.
      if (state_q != IDLE && Tick) tick_cnt_q <= bit_end ? '0 : tick_cnt_q + TW'(1);
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q    <= head_d;
            nbits_q    <= frame_nbits_d;
            stop2_q    <= StopBits;
            par_en_q   <= frame_par_en_d;
            par_bit_q  <= frame_par_bit_d;
            tick_cnt_q <= '0;
            state_q    <= START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == nbits_q - 4'd1) begin
              stop_cnt_q <= 1'b0;
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q    <= STOP;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop2_q && !stop_cnt_q) begin
              stop_cnt_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: a frame-level model (bit list indexed by Tick count)
// compared every cycle, plus hand-computed frame patterns and lengths.
module tb_uart_tx_param;
  localparam int unsigned MAXB  = 9;
  localparam int unsigned OS    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Tick = 1'b0;
  logic          TxValid = 1'b0;
  logic [8:0]    TxData = '0;
  logic          TxReady;
  logic [3:0]    NBits = 4'd8;
  logic          StopBits = 1'b0;
  logic [1:0]    ParityMode = 2'b00;
  logic          Tx, TxBusy, TxDone;
  logic [CW-1:0] FifoCount;

  int tests = 0;
  int fails = 0;

  uart_tx_param #(.MAX_BITS(MAXB), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .TxValid(TxValid), .TxData(TxData),
    .TxReady(TxReady), .NBits(NBits), .StopBits(StopBits), .ParityMode(ParityMode),
    .Tx(Tx), .TxBusy(TxBusy), .TxDone(TxDone), .FifoCount(FifoCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Tick generator: one pulse every second clock while enabled
  bit tick_en = 1'b0;
  int tcyc = 0;
  initial begin
    forever begin
      @(posedge Clk); #1;
      tcyc++;
      Tick = tick_en && tcyc[0];
    end
  end

  // Model: FIFO as a queue, current frame as a list of bit levels each lasting OS ticks
  logic [8:0] mq[$];
  bit  m_busy = 1'b0, m_done = 1'b0;
  int  m_ticks = 0, m_len = 0;
  bit  m_bits[16];
  bit  chk_on = 1'b0;

  task automatic load_frame(input logic [8:0] d);
    int n, k, ones;
    n = int'(NBits);
    if (n < 5) n = 5;
    if (n > int'(MAXB)) n = int'(MAXB);
    k = 0; ones = 0;
    m_bits[k] = 1'b0; k++;
    for (int i = 0; i < n; i++) begin
      m_bits[k] = d[i]; k++;
      ones += int'(d[i]);
    end
`ifdef UART_TX_PARITY_EN
    if (ParityMode == 2'b01) begin m_bits[k] = (ones % 2) == 1; k++; end
    else if (ParityMode == 2'b10) begin m_bits[k] = (ones % 2) == 0; k++; end
`endif
    m_bits[k] = 1'b1; k++;
    if (StopBits) begin m_bits[k] = 1'b1; k++; end
    m_len = k;
  endtask

  // DUT frame capture: mid-bit Tx samples, Tick count per frame, back-to-back starts
  bit          cap_active = 1'b0, prev_done = 1'b0;
  int          cap_ticks = 0, cap_len = 0, cap_frames = 0, b2b = 0;
  logic [15:0] cap_bits = '0, last_bits = '0;

  always @(negedge Clk) begin
    logic exp_tx;
    bit   push_ok;
    if (chk_on) begin
      exp_tx = m_busy ? m_bits[m_ticks / int'(OS)] : 1'b1;
      check("tx",        32'(Tx),        32'(exp_tx));
      check("busy",      32'(TxBusy),    32'(m_busy));
      check("done",      32'(TxDone),    32'(m_done));
      check("fifocount", 32'(FifoCount), 32'(mq.size()));
      check("ready",     32'(TxReady),   32'(mq.size() != DEPTH));
    end

    if (cap_active && TxDone) begin
      cap_active = 1'b0; cap_len = cap_ticks; last_bits = cap_bits; cap_frames++;
    end else if (cap_active && !TxBusy) begin
      cap_active = 1'b0;
    end
    if (!cap_active && TxBusy === 1'b1) begin
      cap_active = 1'b1; cap_ticks = 0; cap_bits = '0;
      if (prev_done) b2b++;
    end
    if (cap_active && Tick) begin
      if (cap_ticks % int'(OS) == int'(OS / 2) && cap_ticks / int'(OS) < 16)
        cap_bits[cap_ticks / int'(OS)] = Tx;
      cap_ticks++;
    end
    prev_done = (TxDone === 1'b1);

    // Advance the model across the coming rising edge using the now-stable inputs
    if (!Rst_n) begin
      mq.delete(); m_busy = 1'b0; m_done = 1'b0; m_ticks = 0;
      chk_on = 1'b1;
    end else begin
      m_done  = 1'b0;
      push_ok = TxValid && (mq.size() < DEPTH);
      if (m_busy) begin
        if (Tick) begin
          m_ticks++;
          if (m_ticks == m_len * int'(OS)) begin m_busy = 1'b0; m_done = 1'b1; end
        end
      end else if (mq.size() > 0) begin
        load_frame(mq.pop_front());
        m_busy = 1'b1; m_ticks = 0;
      end
      if (push_ok) mq.push_back(TxData);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic push(input logic [8:0] d);
    bit ok;
    ok = 1'b0;
    TxValid = 1'b1; TxData = d;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge Clk); ok = TxReady;
      @(posedge Clk); #1;
    end
    TxValid = 1'b0;
    if (!ok) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 6000 && cap_frames < target; i++) cycles(1);
    check("frame_timeout", 32'(cap_frames >= target), 32'd1);
  endtask

  task automatic frame(input logic [8:0] d, input logic [3:0] nb, input logic sb,
                       input logic [1:0] pm, input string nm,
                       input logic [15:0] exp_bits, input int exp_ticks);
    int base;
    NBits = nb; StopBits = sb; ParityMode = pm;
    base = cap_frames;
    push(d);
    wait_frames(base + 1);
    check({nm, "_bits"},  32'(last_bits), 32'(exp_bits));
    check({nm, "_ticks"}, 32'(cap_len),   32'(exp_ticks));
    cycles(3);
  endtask

  initial begin
    int base, b2b0;
    logic [8:0] w[6];
    w[0] = 9'h011; w[1] = 9'h0E2; w[2] = 9'h1F3; w[3] = 9'h004; w[4] = 9'h15A; w[5] = 9'h0AB;

    // Reset with a push offered throughout: nothing may enter the FIFO
    TxValid = 1'b1; TxData = 9'h1AB;
    cycles(3);
    check("rst_tx",    32'(Tx),        32'd1);
    check("rst_busy",  32'(TxBusy),    32'd0);
    check("rst_done",  32'(TxDone),    32'd0);
    check("rst_count", 32'(FifoCount), 32'd0);
    check("rst_ready", 32'(TxReady),   32'd1);
    TxValid = 1'b0; Rst_n = 1'b1;
    tick_en = 1'b1;
    cycles(2);

    // 0x55, 8N1: push into empty FIFO, pop one edge later, start bit the edge after
    NBits = 4'd8; StopBits = 1'b0; ParityMode = 2'b00;
    base = cap_frames;
    TxValid = 1'b1; TxData = 9'h055;
    cycles(1);
    TxValid = 1'b0;
    check("push1_count", 32'(FifoCount), 32'd1);
    check("push1_tx",    32'(Tx),        32'd1);
    cycles(1);
    check("pop_tx",    32'(Tx),        32'd0);
    check("pop_count", 32'(FifoCount), 32'd0);
    check("pop_busy",  32'(TxBusy),    32'd1);
    wait_frames(base + 1);
    check("f55_bits",  32'(last_bits), 32'h2AA);
    check("f55_ticks", 32'(cap_len),   32'd160);
    cycles(3);

`ifdef UART_TX_PARITY_EN
    frame(9'h007, 4'd8, 1'b0, 2'b01, "even07", 16'h060E, 176);
    frame(9'h007, 4'd8, 1'b0, 2'b10, "odd07",  16'h040E, 176);
`else
    frame(9'h007, 4'd8, 1'b0, 2'b01, "even07", 16'h020E, 160);
    frame(9'h007, 4'd8, 1'b0, 2'b10, "odd07",  16'h020E, 160);
`endif
    frame(9'h1F3, 4'd5,  1'b1, 2'b00, "n5s2",   16'h00E6, 128);
    frame(9'h1F3, 4'd15, 1'b0, 2'b00, "nclamp9", 16'h07E6, 176);
    frame(9'h1F3, 4'd3,  1'b0, 2'b00, "nclamp5", 16'h0066, 112);

    // Tick held low: six words offered back-to-back, FIFO fills, frame frozen in START
    NBits = 4'd5; StopBits = 1'b0; ParityMode = 2'b00;
    tick_en = 1'b0;
    cycles(2);
    base = cap_frames; b2b0 = b2b;
    TxValid = 1'b1;
    for (int k = 0; k < 5; k++) begin TxData = w[k]; cycles(1); end
    TxData = w[5];
    cycles(20);
    check("full_count", 32'(FifoCount), 32'd4);
    check("full_ready", 32'(TxReady),   32'd0);
    check("hold_busy",  32'(TxBusy),    32'd1);
    check("hold_tx",    32'(Tx),        32'd0);
    tick_en = 1'b1;
    push(w[5]);
    wait_frames(base + 6);
    check("b2b_starts", 32'(b2b - b2b0), 32'd5);
    cycles(3);

    // Reset during data bit 3 with a second word queued and a push offered on the reset edge
    NBits = 4'd8; StopBits = 1'b0; ParityMode = 2'b00;
    base = cap_frames;
    push(9'h0A5);
    push(9'h03C);
    for (int i = 0; i < 2000 && !(cap_active && cap_ticks >= 4 * int'(OS) + 4); i++) cycles(1);
    check("reach_bit3", 32'(cap_active && cap_ticks >= 4 * int'(OS) + 4), 32'd1);
    Rst_n = 1'b0; TxValid = 1'b1; TxData = 9'h00F;
    cycles(1);
    check("abort_tx",    32'(Tx),        32'd1);
    check("abort_busy",  32'(TxBusy),    32'd0);
    check("abort_count", 32'(FifoCount), 32'd0);
    check("abort_done",  32'(TxDone),    32'd0);
    Rst_n = 1'b1; TxValid = 1'b0;
    cycles(60);
    check("abort_nodone", 32'(cap_frames), 32'(base));

`ifdef UART_TX_PARITY_EN
    frame(9'h05A, 4'd7, 1'b1, 2'b10, "odd5a", 16'h07B4, 176);
`else
    frame(9'h05A, 4'd7, 1'b1, 2'b10, "odd5a", 16'h03B4, 160);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
